// File: rtl/microsequencer_param.sv
// Microprogrammed sequencer: a µPC walks a writable control store; each micro-instruction
// picks the next µPC (increment, dispatch, jump, branch, call/return, home, halt).
module microsequencer_param #(
    parameter int STATE_W     = 4,
    parameter int INP_W       = 2,
    parameter int NUM_DISP    = 2,
    parameter int STACK_DEPTH = 4,
    localparam int DSEL_W     = (NUM_DISP > 1) ? $clog2(NUM_DISP) : 1,
    localparam int MI_W       = 3 + STATE_W,
    localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [INP_W-1:0]   inp,
    input  logic               cond,
    input  logic               cs_we,
    input  logic [STATE_W-1:0] cs_addr,
    input  logic [MI_W-1:0]    cs_wdata,
    input  logic               dt_we,
    input  logic [DSEL_W-1:0]  dt_sel,
    input  logic [INP_W-1:0]   dt_idx,
    input  logic [STATE_W-1:0] dt_wdata,
    output logic [STATE_W-1:0] state,
    output logic [MI_W-1:0]    mi,
    output logic               halted,
    output logic               err,
    output logic [DEPTH_W-1:0] depth
);

    typedef enum logic [2:0] {
        OP_NEXT = 3'b000,
        OP_DISP = 3'b001,
        OP_JUMP = 3'b010,
        OP_BRC  = 3'b011,
        OP_HOME = 3'b100,
        OP_CALL = 3'b101,
        OP_RET  = 3'b110,
        OP_HALT = 3'b111
    } op_e;

    localparam int CS_WORDS   = 2 ** STATE_W;
    localparam int DT_ENTRIES = 2 ** INP_W;
    localparam int SP_W       = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [MI_W-1:0]    cs_mem    [CS_WORDS];
    logic [STATE_W-1:0] dt_mem    [NUM_DISP][DT_ENTRIES];
    logic [STATE_W-1:0] stack_mem [STACK_DEPTH];

    op_e                op;
    logic [STATE_W-1:0] target;
    logic [STATE_W-1:0] state_inc;
    logic [STATE_W-1:0] state_nxt;
    logic [DEPTH_W-1:0] depth_nxt;
    logic [DSEL_W-1:0]  disp_sel;
    logic               disp_ok;
    logic               stack_full;
    logic               stack_empty;
    logic [SP_W-1:0]    push_idx;
    logic [SP_W-1:0]    top_idx;
    logic               push;
    logic               err_set;

    assign mi          = cs_mem[state];
    assign op          = op_e'(mi[2:0]);
    assign target      = mi[MI_W-1:3];
    assign halted      = (op == OP_HALT);
    assign state_inc   = state + 1'b1;
    assign disp_sel    = target[DSEL_W-1:0];
    assign disp_ok     = int'(disp_sel) < NUM_DISP;
    assign stack_full  = (depth == DEPTH_W'(STACK_DEPTH));
    assign stack_empty = (depth == '0);
    assign push_idx    = SP_W'(depth);
    assign top_idx     = SP_W'(depth - 1'b1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_nxt = state;
        depth_nxt = depth;
        push      = 1'b0;
        err_set   = 1'b0;
        unique case (op)
            OP_NEXT: state_nxt = state_inc;
            OP_DISP: begin
                if (disp_ok) begin
                    state_nxt = dt_mem[disp_sel][inp];
                end else begin
                    state_nxt = '0;
                    err_set   = 1'b1;
                end
            end
            OP_JUMP: state_nxt = target;
            OP_BRC:  state_nxt = cond ? target : state_inc;
            OP_HOME: state_nxt = '0;
            OP_CALL: begin
                if (stack_full) begin
                    state_nxt = '0;
                    err_set   = 1'b1;
                end else begin
                    push      = 1'b1;
                    depth_nxt = depth + 1'b1;
                    state_nxt = target;
                end
            end
            OP_RET: begin
                if (stack_empty) begin
                    state_nxt = '0;
                    err_set   = 1'b1;
                end else begin
                    depth_nxt = depth - 1'b1;
                    state_nxt = stack_mem[top_idx];
                end
            end
            OP_HALT: state_nxt = state;
        endcase
    end

    // Microcode and dispatch tables are cleared on reset so a reset sequencer free-runs NEXT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= '0;
            depth <= '0;
            err   <= 1'b0;
            for (int i = 0; i < CS_WORDS; i++) begin
                cs_mem[i] <= '0;
            end
            for (int t = 0; t < NUM_DISP; t++) begin
                for (int e = 0; e < DT_ENTRIES; e++) begin
                    dt_mem[t][e] <= '0;
                end
            end
        end else begin
            if (cs_we) begin
                cs_mem[cs_addr] <= cs_wdata;
            end
            if (dt_we && (int'(dt_sel) < NUM_DISP)) begin
                dt_mem[dt_sel][dt_idx] <= dt_wdata;
            end
            if (en) begin
                state <= state_nxt;
                depth <= depth_nxt;
                err   <= err | err_set;
            end
        end
    end

    // NOTE: the return stack has no reset; entries at or above depth are never read.
    always_ff @(posedge clk) begin
        if (rst_n && en && push) begin
            stack_mem[push_idx] <= state_inc;
        end
    end

endmodule

// File: tb/tb_microsequencer_param.sv
// Directed bench for microsequencer_param: wrap, dispatch, call/return, stack overflow,
// branch, stall, halt exit by rewrite and return-stack underflow.
module tb_microsequencer_param;

    localparam logic [2:0] OP_NEXT = 3'b000;
    localparam logic [2:0] OP_DISP = 3'b001;
    localparam logic [2:0] OP_JUMP = 3'b010;
    localparam logic [2:0] OP_BRC  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b101;
    localparam logic [2:0] OP_RET  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] inp;
    logic       cond;
    logic       cs_we;
    logic [3:0] cs_addr;
    logic [6:0] cs_wdata;
    logic       dt_we;
    logic       dt_sel;
    logic [1:0] dt_idx;
    logic [3:0] dt_wdata;
    logic [3:0] state;
    logic [6:0] mi;
    logic       halted;
    logic       err;
    logic [2:0] depth;

    int n_tests = 0;
    int n_fail  = 0;

    microsequencer_param dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .inp      (inp),
        .cond     (cond),
        .cs_we    (cs_we),
        .cs_addr  (cs_addr),
        .cs_wdata (cs_wdata),
        .dt_we    (dt_we),
        .dt_sel   (dt_sel),
        .dt_idx   (dt_idx),
        .dt_wdata (dt_wdata),
        .state    (state),
        .mi       (mi),
        .halted   (halted),
        .err      (err),
        .depth    (depth)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic cs_write(input logic [3:0] a, input logic [2:0] op, input logic [3:0] tgt);
        cs_we    = 1'b1;
        cs_addr  = a;
        cs_wdata = {tgt, op};
        step();
        cs_we    = 1'b0;
    endtask

    task automatic dt_write(input logic t, input logic [1:0] idx, input logic [3:0] val);
        dt_we    = 1'b1;
        dt_sel   = t;
        dt_idx   = idx;
        dt_wdata = val;
        step();
        dt_we    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; inp = '0; cond = 1'b0;
        cs_we = 1'b0; cs_addr = '0; cs_wdata = '0;
        dt_we = 1'b0; dt_sel = 1'b0; dt_idx = '0; dt_wdata = '0;

        // Reset with a write attempt that must be ignored
        cs_we = 1'b1; cs_addr = 4'd0; cs_wdata = {4'd7, OP_JUMP};
        step();
        step();
        cs_we = 1'b0;
        rst_n = 1'b1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mi", 32'(mi), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        // Free-run NEXT with wrap
        en = 1'b1;
        for (int i = 1; i < 20; i++) begin
            step();
            check("wrap_state", 32'(state), 32'(i % 16));
        end
        check("wrap_err", 32'(err), 32'd0);

        // Dispatch through table 1
        en = 1'b0;
        do_reset();
        cs_write(4'd0, OP_DISP, 4'd1);
        dt_write(1'b1, 2'd0, 4'd11);
        dt_write(1'b1, 2'd1, 4'd12);
        dt_write(1'b1, 2'd2, 4'd12);
        dt_write(1'b1, 2'd3, 4'd12);
        check("disp_mi", 32'(mi), 32'h09);
        check("disp_hold", 32'(state), 32'd0);
        inp = 2'd0; en = 1'b1;
        step();
        check("disp_inp0", 32'(state), 32'd11);
        repeat (5) step();
        check("disp_back0", 32'(state), 32'd0);
        inp = 2'd2;
        step();
        check("disp_inp2", 32'(state), 32'd12);
        check("disp_err", 32'(err), 32'd0);

        // Call, return, halt
        en = 1'b0;
        do_reset();
        cs_write(4'd0, OP_CALL, 4'd8);
        cs_write(4'd8, OP_NEXT, 4'd0);
        cs_write(4'd9, OP_RET, 4'd0);
        cs_write(4'd1, OP_HALT, 4'd0);
        check("call_s0", 32'(state), 32'd0);
        check("call_d0", 32'(depth), 32'd0);
        en = 1'b1;
        step();
        check("call_s1", 32'(state), 32'd8);
        check("call_d1", 32'(depth), 32'd1);
        step();
        check("call_s2", 32'(state), 32'd9);
        check("call_d2", 32'(depth), 32'd1);
        step();
        check("ret_s3", 32'(state), 32'd1);
        check("ret_d3", 32'(depth), 32'd0);
        check("ret_halted", 32'(halted), 32'd1);
        step();
        check("halt_s4", 32'(state), 32'd1);
        check("halt_h4", 32'(halted), 32'd1);

        // Stack overflow
        en = 1'b0;
        do_reset();
        cs_write(4'd0, OP_CALL, 4'd0);
        en = 1'b1;
        for (int d = 1; d <= 4; d++) begin
            step();
            check("ovf_depth", 32'(depth), 32'(d));
            check("ovf_state", 32'(state), 32'd0);
            check("ovf_err_pre", 32'(err), 32'd0);
        end
        step();
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_state5", 32'(state), 32'd0);
        check("ovf_depth5", 32'(depth), 32'd4);
        do_reset();
        check("rst2_state", 32'(state), 32'd0);
        check("rst2_depth", 32'(depth), 32'd0);
        check("rst2_err", 32'(err), 32'd0);
        check("rst2_mi", 32'(mi), 32'd0);

        // Conditional branch and stall
        en = 1'b0;
        cs_write(4'd3, OP_BRC, 4'd10);
        cond = 1'b0; en = 1'b1;
        repeat (3) step();
        check("brc_at3", 32'(state), 32'd3);
        step();
        check("brc_nt", 32'(state), 32'd4);
        repeat (15) step();
        check("brc_at3b", 32'(state), 32'd3);
        cond = 1'b1;
        step();
        check("brc_t", 32'(state), 32'd10);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_state", 32'(state), 32'd10);
        end

        // Halt exited by rewriting the current word
        cs_write(4'd5, OP_HALT, 4'd0);
        cs_write(4'd10, OP_JUMP, 4'd5);
        en = 1'b1;
        step();
        check("halt_at5", 32'(state), 32'd5);
        check("halt_flag5", 32'(halted), 32'd1);
        step();
        check("halt_hold5", 32'(state), 32'd5);
        cs_we = 1'b1; cs_addr = 4'd5; cs_wdata = {4'd2, OP_JUMP};
        step();
        cs_we = 1'b0;
        check("rewrite_hold", 32'(state), 32'd5);
        check("rewrite_mi", 32'(mi), 32'h12);
        check("rewrite_halted", 32'(halted), 32'd0);
        step();
        check("rewrite_jump", 32'(state), 32'd2);

        // Return with empty stack
        en = 1'b0;
        cs_write(4'd2, OP_RET, 4'd0);
        check("unf_err_pre", 32'(err), 32'd0);
        en = 1'b1;
        step();
        check("unf_state", 32'(state), 32'd0);
        check("unf_err", 32'(err), 32'd1);
        check("unf_depth", 32'(depth), 32'd0);
        en = 1'b0;
        step();
        check("err_sticky", 32'(err), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
